// File: rtl/kernel_cc_start_arb.sv
// rtl/kernel_cc_start_arb.sv - round-robin arbiter for a shared kernel_cc start-token FIFO write port
module kernel_cc_start_arb #(
    parameter int NUM_REQ   = 4,
    parameter int IDX_WIDTH = 2,
    parameter int DEPTH     = 4,
    parameter int CNT_WIDTH = 3
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic [NUM_REQ-1:0]   req_i,
    output logic [NUM_REQ-1:0]   ack_o,
    input  logic                 fifo_full_n_i,
    output logic                 fifo_write_o,
    output logic                 fifo_write_ce_o,
    output logic [IDX_WIDTH-1:0] fifo_din_o,
    input  logic                 fifo_rd_fire_i,
    input  logic                 flush_i,
    output logic                 flush_done_o,
    output logic [CNT_WIDTH-1:0] occupancy_o
);

    typedef enum logic [1:0] {IDLE, WRITE, DRAIN} state_t;

    state_t               state_q, state_d;
    logic [IDX_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_WIDTH-1:0] din_q, din_d;
    logic [CNT_WIDTH-1:0] occ_q, occ_d;
    logic                 flush_done_q, flush_done_d;

    logic                 fire;
    logic                 found;
    logic [IDX_WIDTH-1:0] winner;
    logic                 inc;
    logic                 dec;
    logic                 below_depth;
    int                   idx;

    // Scan from rr_ptr upward, wrapping, and take the first asserted request.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(rr_ptr_q) + i) % NUM_REQ;
            if (!found && req_i[idx]) begin
                found  = 1'b1;
                winner = IDX_WIDTH'(idx);
            end
        end
    end

    assign below_depth = (occ_q < CNT_WIDTH'(DEPTH));
    assign fire        = (state_q == WRITE) && fifo_full_n_i;
    assign inc         = fire && below_depth;
    assign dec         = fifo_rd_fire_i && (occ_q != '0);

    always_comb begin
        occ_d = occ_q;
        if (inc && !dec) begin
            occ_d = occ_q + CNT_WIDTH'(1);
        end else if (dec && !inc) begin
            occ_d = occ_q - CNT_WIDTH'(1);
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        din_d        = din_q;
        flush_done_d = flush_done_q;
        case (state_q)
            IDLE: begin
                if (flush_i) begin
                    state_d = DRAIN;
                end else if (found && below_depth) begin
                    din_d   = winner;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                // The latched winner is committed even if its request drops.
                if (fifo_full_n_i) begin
                    rr_ptr_d = (din_q == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : din_q + IDX_WIDTH'(1);
                    state_d  = IDLE;
                end
            end
            DRAIN: begin
                if (!flush_i) begin
                    flush_done_d = 1'b0;
                    state_d      = IDLE;
                end else begin
                    flush_done_d = (occ_q == '0);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            din_q        <= '0;
            occ_q        <= '0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            din_q        <= din_d;
            occ_q        <= occ_d;
            flush_done_q <= flush_done_d;
        end
    end

    assign fifo_write_o    = (state_q == WRITE);
    assign fifo_write_ce_o = reset_ni;
    assign fifo_din_o      = din_q;
    assign ack_o           = fire ? (NUM_REQ'(1) << din_q) : '0;
    assign flush_done_o    = flush_done_q;
    assign occupancy_o     = occ_q;

endmodule

// File: tb/tb_kernel_cc_start_arb.sv
// tb/tb_kernel_cc_start_arb.sv - self-checking bench for kernel_cc_start_arb
module tb_kernel_cc_start_arb;

    logic       clk;
    logic       reset_n;
    logic [3:0] req;
    logic [3:0] ack;
    logic       full_n;
    logic       fifo_write;
    logic       write_ce;
    logic [1:0] din;
    logic       rd_fire;
    logic       flush;
    logic       flush_done;
    logic [2:0] occ;

    int n_checks = 0;
    int n_fail   = 0;

    // Abstract model: pending token index (-1 = none), drain mode, pointer, count.
    int m_pending;
    int m_rr;
    int m_occ;
    bit m_drain;
    bit m_fd;

    typedef struct {
        logic [3:0] req;
        logic       full_n;
        logic       rd;
        logic       flush;
        logic       exp_write;
        logic [1:0] exp_din;
        logic [3:0] exp_ack;
        logic [2:0] exp_occ;
    } vec_t;

    vec_t tbl [12];

    kernel_cc_start_arb #(
        .NUM_REQ(4), .IDX_WIDTH(2), .DEPTH(4), .CNT_WIDTH(3)
    ) dut (
        .clk_i          (clk),
        .reset_ni       (reset_n),
        .req_i          (req),
        .ack_o          (ack),
        .fifo_full_n_i  (full_n),
        .fifo_write_o   (fifo_write),
        .fifo_write_ce_o(write_ce),
        .fifo_din_o     (din),
        .fifo_rd_fire_i (rd_fire),
        .flush_i        (flush),
        .flush_done_o   (flush_done),
        .occupancy_o    (occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pending = -1;
        m_rr      = 0;
        m_occ     = 0;
        m_drain   = 0;
        m_fd      = 0;
    endtask

    // Apply inputs just after an edge, then compare against the model at mid-cycle.
    task automatic drive(input logic [3:0] r, input logic f, input logic rd, input logic fl);
        logic [31:0] exp_ack;
        req     = r;
        full_n  = f;
        rd_fire = rd;
        flush   = fl;
        #4;
        exp_ack = (m_pending >= 0 && f) ? (32'd1 << m_pending) : 32'd0;
        check("fifo_write", 32'(fifo_write), 32'(m_pending >= 0));
        if (m_pending >= 0) check("fifo_din", 32'(din), 32'(m_pending));
        check("ack", 32'(ack), exp_ack);
        check("occupancy", 32'(occ), 32'(m_occ));
        check("flush_done", 32'(flush_done), 32'(m_fd));
        check("fifo_write_ce", 32'(write_ce), 32'd1);
    endtask

    task automatic tick();
        bit fire;
        bit found;
        int occ_next;
        @(posedge clk);
        fire     = (m_pending >= 0) && full_n;
        occ_next = m_occ + (fire ? 1 : 0) - ((rd_fire && m_occ > 0) ? 1 : 0);
        if (m_pending >= 0) begin
            if (fire) begin
                m_rr      = (m_pending + 1) % 4;
                m_pending = -1;
            end
        end else if (m_drain) begin
            if (!flush) begin
                m_drain = 0;
                m_fd    = 0;
            end else begin
                m_fd = (m_occ == 0);
            end
        end else if (flush) begin
            m_drain = 1;
        end else if (m_occ < 4) begin
            found = 0;
            for (int k = 0; k < 4; k++) begin
                if (!found && req[(m_rr + k) % 4]) begin
                    found     = 1;
                    m_pending = (m_rr + k) % 4;
                end
            end
        end
        m_occ = occ_next;
        #1;
    endtask

    initial begin
        tbl[0]  = '{4'b0001, 1, 0, 0, 0, 2'd0, 4'b0000, 3'd0};
        tbl[1]  = '{4'b0001, 1, 0, 0, 1, 2'd0, 4'b0001, 3'd0};
        tbl[2]  = '{4'b0000, 1, 1, 0, 0, 2'd0, 4'b0000, 3'd1};
        tbl[3]  = '{4'b1111, 1, 0, 0, 0, 2'd0, 4'b0000, 3'd0};
        tbl[4]  = '{4'b1111, 1, 0, 0, 1, 2'd1, 4'b0010, 3'd0};
        tbl[5]  = '{4'b1111, 1, 1, 0, 0, 2'd0, 4'b0000, 3'd1};
        tbl[6]  = '{4'b1111, 1, 0, 0, 1, 2'd2, 4'b0100, 3'd0};
        tbl[7]  = '{4'b1111, 1, 1, 0, 0, 2'd0, 4'b0000, 3'd1};
        tbl[8]  = '{4'b1111, 1, 0, 0, 1, 2'd3, 4'b1000, 3'd0};
        tbl[9]  = '{4'b1111, 1, 1, 0, 0, 2'd0, 4'b0000, 3'd1};
        tbl[10] = '{4'b1111, 1, 0, 0, 1, 2'd0, 4'b0001, 3'd0};
        tbl[11] = '{4'b0000, 1, 1, 0, 0, 2'd0, 4'b0000, 3'd1};

        reset_n = 1'b0;
        req     = '0;
        full_n  = 1'b1;
        rd_fire = 1'b0;
        flush   = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset fifo_write", 32'(fifo_write), 0);
        check("reset fifo_din", 32'(din), 0);
        check("reset occupancy", 32'(occ), 0);
        check("reset flush_done", 32'(flush_done), 0);
        check("reset fifo_write_ce", 32'(write_ce), 0);
        reset_n = 1'b1;

        // single request followed by round robin with a read per write
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].req, tbl[i].full_n, tbl[i].rd, tbl[i].flush);
            check($sformatf("tbl%0d write", i), 32'(fifo_write), 32'(tbl[i].exp_write));
            if (tbl[i].exp_write) check($sformatf("tbl%0d din", i), 32'(din), 32'(tbl[i].exp_din));
            check($sformatf("tbl%0d ack", i), 32'(ack), 32'(tbl[i].exp_ack));
            check($sformatf("tbl%0d occ", i), 32'(occ), 32'(tbl[i].exp_occ));
            tick();
        end

        // backpressure on winner 2
        drive(4'b0100, 1, 0, 0); tick();
        for (int i = 0; i < 5; i++) begin
            drive(4'b0100, 0, 0, 0);
            check("bp write held", 32'(fifo_write), 1);
            check("bp din held", 32'(din), 2);
            check("bp no ack", 32'(ack), 0);
            tick();
        end
        drive(4'b0100, 1, 0, 0);
        check("bp ack", 32'(ack), 32'b0100);
        tick();
        drive(4'b0000, 1, 0, 0);
        check("bp write drop", 32'(fifo_write), 0);
        tick();

        // occupancy cap
        for (int i = 0; i < 20 && m_occ < 4; i++) begin
            drive(4'b1111, 1, 0, 0); tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(4'b0001, 1, 0, 0);
            check("cap no write", 32'(fifo_write), 0);
            check("cap occ", 32'(occ), 4);
            tick();
        end
        drive(4'b0001, 1, 1, 0); tick();
        drive(4'b0001, 1, 0, 0);
        check("cap occ after read", 32'(occ), 3);
        tick();
        drive(4'b0001, 1, 1, 0);
        check("cap grant", 32'(fifo_write), 1);
        tick();
        drive(4'b0000, 1, 0, 0);
        check("write+read occ", 32'(occ), 3);
        tick();

        // flush / drain
        drive(4'b0000, 1, 1, 0); tick();
        for (int i = 0; i < 4; i++) begin
            drive(4'b1111, 1, 0, 1);
            check("flush no write", 32'(fifo_write), 0);
            check("flush no ack", 32'(ack), 0);
            check("flush_done early", 32'(flush_done), 0);
            tick();
        end
        drive(4'b1111, 1, 1, 1); tick();
        drive(4'b1111, 1, 1, 1); tick();
        drive(4'b1111, 1, 0, 1);
        check("drain occ", 32'(occ), 0);
        check("drain fd before", 32'(flush_done), 0);
        tick();
        drive(4'b1111, 1, 0, 1);
        check("drain fd", 32'(flush_done), 1);
        tick();
        drive(4'b1111, 1, 0, 0);
        check("fd held until edge", 32'(flush_done), 1);
        tick();
        drive(4'b1111, 1, 0, 0);
        check("fd cleared", 32'(flush_done), 0);
        check("no write on exit", 32'(fifo_write), 0);
        tick();
        drive(4'b1111, 1, 0, 0);
        check("resume din", 32'(din), 1);
        check("resume ack", 32'(ack), 32'b0010);
        tick();
        drive(4'b0000, 1, 1, 0); tick();

        // async reset in the middle of a stalled write
        drive(4'b1000, 0, 0, 0); tick();
        drive(4'b1000, 0, 0, 0);
        check("pre-reset write", 32'(fifo_write), 1);
        full_n = 1'b1;
        #1;
        reset_n = 1'b0;
        #1;
        check("async write", 32'(fifo_write), 0);
        check("async din", 32'(din), 0);
        check("async ack", 32'(ack), 0);
        check("async occ", 32'(occ), 0);
        check("async fd", 32'(flush_done), 0);
        check("async ce", 32'(write_ce), 0);
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        drive(4'b1010, 1, 0, 0); tick();
        drive(4'b1010, 1, 0, 0);
        check("post-reset din", 32'(din), 1);
        check("post-reset ack", 32'(ack), 32'b0010);
        tick();

        // randomized run against the model
        begin
            logic fl_r;
            fl_r = 1'b0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 39) == 0) fl_r = ~fl_r;
                drive(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
                      1'($urandom_range(0, 1)), fl_r);
                tick();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
